// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller: segment codes,
// special glyphs and the binary-to-BCD converter state encoding.
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_e;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    // Active-low g..a codes, entry n is the glyph for nibble value n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    // Decimal digits needed for any DATA_W-bit value (floor(w*log10 2)+1),
    // never fewer than the number of displayed digits.
    function automatic int bcd_digits(input int data_w, input int num_digits);
        int d;
        d = (data_w * 3) / 10 + 1;
        return (d > num_digits) ? d : num_digits;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, result valid
// while done is high (the single LOAD cycle).
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int NUM_DIGITS = 4,
    localparam int BCD_W     = 4 * bcd_digits(DATA_W, NUM_DIGITS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    localparam int CNT_W = $clog2(DATA_W);

    conv_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [DATA_W-1:0] src_bin;
    logic [BCD_W-1:0]  adj;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;

        // The first step takes its operand straight from din (held stable
        // by the caller for the whole conversion) and starts from zero BCD.
        src_bin = (cnt_q == '0) ? din : bin_q;
        adj     = (cnt_q == '0) ? '0  : bcd_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                bcd_d = {adj[BCD_W-2:0], src_bin[DATA_W-1]};
                bin_d = {src_bin[DATA_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = LOAD;
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == LOAD);
    assign bcd  = bcd_q;

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment display driver: periodically samples a binary
// value, converts it to hex or decimal digits and scans them onto the display.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14,
    parameter int UPDATE_DIV = 100000000,
    parameter int SCAN_DIV   = 262144
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     value,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_in,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  busy,
    output logic                  overflow
);

    localparam int BCD_W  = 4 * bcd_digits(DATA_W, NUM_DIGITS);
    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int EXT_W  = (DATA_W > DISP_W) ? DATA_W : DISP_W;
    localparam int UPD_W  = $clog2(UPDATE_DIV);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [UPD_W-1:0]      upd_cnt_q, upd_cnt_d;
    logic [DATA_W-1:0]     shadow_val_q, shadow_val_d;
    logic                  shadow_hex_q, shadow_hex_d;
    logic [DISP_W-1:0]     disp_q, disp_d;
    logic                  ovf_q, ovf_d;
    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic              tick;
    logic              accept;
    logic              conv_busy;
    logic              conv_done;
    logic [BCD_W-1:0]  conv_bcd;
    logic [EXT_W-1:0]  hex_ext;
    logic              scan_wrap;
    logic [3:0]        nib;
    logic              dp_sel;
    logic              zero_from;
    logic              lead_zero;

    assign tick    = (upd_cnt_q == UPD_W'(UPDATE_DIV - 1));
    assign accept  = tick && !conv_busy;
    assign hex_ext = EXT_W'(value);

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (accept && !hex_mode),
        .din   (shadow_val_q),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        upd_cnt_d    = tick ? '0 : upd_cnt_q + 1'b1;
        shadow_val_d = shadow_val_q;
        shadow_hex_d = shadow_hex_q;
        disp_d       = disp_q;
        ovf_d        = ovf_q;

        // Ticks during a conversion are dropped so the shadow stays stable.
        if (accept) begin
            shadow_val_d = value;
            shadow_hex_d = hex_mode;
        end

        if (accept && hex_mode) begin
            disp_d = hex_ext[DISP_W-1:0];
            ovf_d  = |(hex_ext >> DISP_W);
        end else if (conv_done && !shadow_hex_q) begin
            disp_d = conv_bcd[DISP_W-1:0];
            ovf_d  = |(conv_bcd >> DISP_W);
        end
    end

    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_wrap) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        nib    = '0;
        dp_sel = 1'b0;
        an_d   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib     = disp_q[4*i +: 4];
                dp_sel  = dp_in[i];
                an_d[i] = 1'b0;
            end
        end

        // Walk down from the top digit; digit 0 is never a leading zero.
        zero_from = 1'b1;
        lead_zero = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_from = zero_from && (disp_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                lead_zero = zero_from;
            end
        end

        if (ovf_q) begin
            seg_d = DASH;
            dp_d  = 1'b1;
        end else begin
            seg_d = (blank_lz && lead_zero) ? BLANK : SEG_TABLE[nib];
            dp_d  = ~dp_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_cnt_q    <= '0;
            shadow_val_q <= '0;
            shadow_hex_q <= 1'b0;
            disp_q       <= '0;
            ovf_q        <= 1'b0;
            scan_cnt_q   <= '0;
            idx_q        <= '0;
            an_q         <= '1;
            seg_q        <= BLANK;
            dp_q         <= 1'b1;
        end else begin
            upd_cnt_q    <= upd_cnt_d;
            shadow_val_q <= shadow_val_d;
            shadow_hex_q <= shadow_hex_d;
            disp_q       <= disp_d;
            ovf_q        <= ovf_d;
            scan_cnt_q   <= scan_cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign busy     = conv_busy;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl: a 4-digit instance for conversion and
// display behaviour, and a 3-digit instance for the scan sequence.
module tb_ssd_scan_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [13:0] value_a;
    logic        hex_a, blz_a;
    logic [3:0]  dpin_a;
    logic [3:0]  an_a;
    logic [6:0]  seg_a;
    logic        dp_a, busy_a, ovf_a;

    logic [13:0] value_b;
    logic        hex_b, blz_b;
    logic [2:0]  dpin_b;
    logic [2:0]  an_b;
    logic [6:0]  seg_b;
    logic        dp_b, busy_b, ovf_b;

    int total = 0;
    int bad   = 0;
    int n;
    logic [2:0] pat [3];

    ssd_scan_ctrl #(.NUM_DIGITS(4), .DATA_W(14), .UPDATE_DIV(32), .SCAN_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .value(value_a), .hex_mode(hex_a),
        .blank_lz(blz_a), .dp_in(dpin_a), .an(an_a), .seg(seg_a),
        .dp(dp_a), .busy(busy_a), .overflow(ovf_a)
    );

    ssd_scan_ctrl #(.NUM_DIGITS(3), .DATA_W(14), .UPDATE_DIV(32), .SCAN_DIV(4)) dut_b (
        .clk(clk), .reset(reset), .value(value_b), .hex_mode(hex_b),
        .blank_lz(blz_b), .dp_in(dpin_b), .an(an_b), .seg(seg_b),
        .dp(dp_b), .busy(busy_b), .overflow(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_busy_a(input logic lvl, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy_a === lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic conv_a(input string tag);
        wait_busy_a(1'b1, {tag, "_rise"});
        wait_busy_a(1'b0, {tag, "_fall"});
    endtask

    task automatic digit_a(input int k, input logic [6:0] seg_e, input logic dp_e, input string tag);
        bit ok;
        logic [3:0] mask;
        ok   = 1'b0;
        mask = ~(4'b0001 << k);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (an_a === mask) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_an"}, {31'd0, ok}, 32'd1);
        chk({tag, "_seg"}, {25'd0, seg_a}, {25'd0, seg_e});
        chk({tag, "_dp"}, {31'd0, dp_a}, {31'd0, dp_e});
    endtask

    task automatic wait_an_b(input logic [2:0] want, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (an_b === want) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        value_a = '0; hex_a = 1'b0; blz_a = 1'b0; dpin_a = 4'b0000;
        value_b = '0; hex_b = 1'b0; blz_b = 1'b0; dpin_b = 3'b010;
        pat[0] = 3'b110; pat[1] = 3'b101; pat[2] = 3'b011;

        // Reset values
        step(3);
        chk("rst_an", {28'd0, an_a}, 32'hF);
        chk("rst_seg", {25'd0, seg_a}, 32'h7F);
        chk("rst_dp", {31'd0, dp_a}, 32'd1);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
        chk("rst_an_b", {29'd0, an_b}, 32'h7);
        reset = 1'b0;

        // Decimal 1234: busy 14 shifts + 1 load
        value_a = 14'd1234;
        wait_busy_a(1'b1, "tmo_1234_rise");
        n = 0;
        while (busy_a === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len_1234", n, 32'd15);
        chk("ovf_1234", {31'd0, ovf_a}, 32'd0);
        digit_a(3, 7'b1111001, 1'b1, "d3_1234");
        digit_a(2, 7'b0100100, 1'b1, "d2_1234");
        digit_a(1, 7'b0110000, 1'b1, "d1_1234");
        digit_a(0, 7'b0011001, 1'b1, "d0_1234");

        // 9999 fits, 10000 overflows, 42 clears
        wait_busy_a(1'b0, "tmo_idle_9999");
        value_a = 14'd9999;
        conv_a("conv_9999");
        chk("ovf_9999", {31'd0, ovf_a}, 32'd0);
        digit_a(3, 7'b0010000, 1'b1, "d3_9999");
        wait_busy_a(1'b0, "tmo_idle_10000");
        value_a = 14'd10000;
        dpin_a  = 4'b1111;
        conv_a("conv_10000");
        chk("ovf_10000", {31'd0, ovf_a}, 32'd1);
        for (int k = 3; k >= 0; k--) begin
            digit_a(k, 7'b0111111, 1'b1, $sformatf("dash_d%0d", k));
        end
        wait_busy_a(1'b0, "tmo_idle_42");
        value_a = 14'd42;
        blz_a   = 1'b1;
        conv_a("conv_42");
        chk("ovf_42", {31'd0, ovf_a}, 32'd0);
        digit_a(3, 7'b1111111, 1'b0, "d3_42_blank");
        digit_a(2, 7'b1111111, 1'b0, "d2_42_blank");
        digit_a(1, 7'b0011001, 1'b0, "d1_42");
        digit_a(0, 7'b0100100, 1'b0, "d0_42");

        // Hex 0x3AF: direct load, no busy pulse
        wait_busy_a(1'b0, "tmo_idle_hex");
        dpin_a  = 4'b0000;
        hex_a   = 1'b1;
        value_a = 14'h3AF;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_a !== 1'b0) n++;
            @(negedge clk);
        end
        chk("hex_busy_cycles", n, 32'd0);
        chk("ovf_hex", {31'd0, ovf_a}, 32'd0);
        digit_a(3, 7'b1111111, 1'b1, "hex_d3_blank");
        digit_a(2, 7'b0110000, 1'b1, "hex_d2");
        digit_a(1, 7'b0001000, 1'b1, "hex_d1");
        digit_a(0, 7'b0001110, 1'b1, "hex_d0");
        blz_a = 1'b0;
        digit_a(3, 7'b1000000, 1'b1, "hex_d3_zero");

        // Tick forced mid-conversion is ignored
        hex_a   = 1'b0;
        value_a = 14'd111;
        wait_busy_a(1'b1, "tmo_111_rise");
        n = 0;
        while (busy_a === 1'b1 && n < 60) begin
            if (n == 3) begin
                value_a = 14'd222;
                force dut_a.tick = 1'b1;
            end
            if (n == 4) release dut_a.tick;
            n++;
            @(negedge clk);
        end
        chk("busy_len_111", n, 32'd15);
        digit_a(0, 7'b1111001, 1'b1, "d0_111");
        conv_a("conv_222");
        digit_a(0, 7'b0100100, 1'b1, "d0_222");

        // Reset at shift cycle 5 aborts the conversion
        wait_busy_a(1'b0, "tmo_idle_5555");
        value_a = 14'd5555;
        wait_busy_a(1'b1, "tmo_5555_rise");
        step(4);
        reset = 1'b1;
        #1;
        chk("abort_an", {28'd0, an_a}, 32'hF);
        chk("abort_seg", {25'd0, seg_a}, 32'h7F);
        chk("abort_dp", {31'd0, dp_a}, 32'd1);
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_ovf", {31'd0, ovf_a}, 32'd0);
        step(2);
        reset = 1'b0;
        digit_a(1, 7'b1000000, 1'b1, "abort_d1_zero");
        conv_a("conv_5555");
        digit_a(0, 7'b0010010, 1'b1, "d0_5555");

        // Three-digit scan order, hold time and decimal point
        wait_an_b(3'b011, "tmo_scan_b_011");
        wait_an_b(3'b110, "tmo_scan_b_110");
        for (int j = 0; j < 13; j++) begin
            chk($sformatf("scan_an_%0d", j), {29'd0, an_b}, {29'd0, pat[(j / 4) % 3]});
            chk($sformatf("scan_dp_%0d", j), {31'd0, dp_b},
                {31'd0, (pat[(j / 4) % 3] == 3'b101) ? 1'b0 : 1'b1});
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter DATA_W, default 14, binary input width (legal 4..27).
REQ-003 SHALL have parameter UPDATE_DIV, default 100000000, clk cycles between display-value samples (legal > DATA_W+2).
REQ-004 SHALL have parameter SCAN_DIV, default 262144, clk cycles each digit stays enabled (legal >= 2).
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high.
REQ-007 SHALL have port value  input  DATA_W  unsigned binary value to display.
REQ-008 SHALL have port hex_mode  input  1  1 = hexadecimal digits, 0 = decimal.
REQ-009 SHALL have port blank_lz  input  1  1 = blank leading zero digits.
REQ-010 SHALL have port dp_in  input  NUM_DIGITS  per-digit decimal point request, bit i = digit i.
REQ-011 SHALL have port an  output  NUM_DIGITS  active-low digit enables, an[0] = rightmost, least-significant digit.
REQ-012 SHALL have port seg  output  7  active-low segments, bit order g..a (seg[6]=g).
REQ-013 SHALL have port dp  output  1  active-low decimal point.
REQ-014 SHALL have port busy  output  1  high while decimal conversion is in progress.
REQ-015 SHALL have port overflow  output  1  high while the shown value does not fit NUM_DIGITS digits.

Function
REQ-016 Update divider SHALL count 0..UPDATE_DIV-1, wrap to 0, and pulse tick for one cycle when count = UPDATE_DIV-1.
REQ-017 On tick, the block SHALL sample value and hex_mode into a shadow register; blank_lz and dp_in are used live.
REQ-018 Converter FSM states SHALL be IDLE, SHIFT and LOAD; IDLE->SHIFT on tick with hex_mode=0, SHIFT->LOAD after exactly DATA_W shift cycles, LOAD->IDLE unconditionally.
REQ-019 SHIFT SHALL perform one double-dabble step per cycle (add 3 to every BCD nibble >= 5, then shift left one bit); busy = 1 in SHIFT and LOAD only.
REQ-020 Decimal latency SHALL be tick at cycle t -> display register updated at edge t+DATA_W+2; the display register SHALL change atomically, never showing partial results.
REQ-021 With sampled hex_mode=1, the display register SHALL load value nibbles directly at edge t+1 without leaving IDLE; busy stays 0.
REQ-022 A tick arriving while not in IDLE SHALL be ignored; the sample is lost and the current conversion completes unaffected.
REQ-023 overflow SHALL be set in LOAD when the decimal result >= 10^NUM_DIGITS, or at hex load when value bits above 4*NUM_DIGITS-1 are nonzero; otherwise cleared at the same load.
REQ-024 While overflow = 1, every enabled digit SHALL show dash (seg = 0111111), with no blanking and dp off.
REQ-025 Scan prescaler SHALL count 0..SCAN_DIV-1; on wrap, digit index increments, wrapping from NUM_DIGITS-1 to 0.
REQ-026 an, seg and dp SHALL be registered, reflecting the digit index one cycle later; exactly one an bit is low at any time after the first scan-clock edge.
REQ-027 Segment codes (g..a, active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-028 With blank_lz = 1, digit i > 0 SHALL show 1111111 when it and all higher digits are 0; digit 0 is never blanked.
REQ-029 dp SHALL equal ~dp_in[index], including on blanked digits, except under REQ-024.

Reset
REQ-030 reset SHALL asynchronously clear all counters, the digit index, the shadow and display registers, and the FSM to IDLE.
REQ-031 During and after reset until the first edge: an = all ones, seg = 1111111, dp = 1, busy = 0, overflow = 0.
REQ-032 Reset asserted mid-conversion SHALL abort it; no partial value is ever loaded into the display register.

Structure
REQ-033 Shared package ssd_pkg SHALL hold the 16-entry segment table and the BLANK (1111111) and DASH (0111111) constants, plus the FSM state encodings.
REQ-034 The double-dabble datapath SHALL be sub-module bin2bcd_seq (start/busy/done handshake, parameters DATA_W and NUM_DIGITS).

Verification
REQ-035 UPDATE_DIV=32, DATA_W=14, value=1234, decimal -> busy for exactly 15 cycles, then digits 3..0 show 1,2,3,4 (seg 1111001, 0100100, 0110000, 0011001).
REQ-036 value=9999 then 10000, NUM_DIGITS=4 -> second load sets overflow=1 and all digits show 0111111; 42 next clears overflow.
REQ-037 hex_mode=1, value=0x3AF, blank_lz=1 -> digit3 blank, digits 2..0 show 3, A, F with no busy pulse; blank_lz=0 -> digit3 shows 0.
REQ-038 Value changed and tick forced during SHIFT -> tick ignored; display shows the first value; the next tick converts the new value.
REQ-039 reset pulsed at shift cycle 5 of 14 -> outputs return to reset values immediately; after release, no display load until the next tick completes.
REQ-040 NUM_DIGITS=3, SCAN_DIV=4 -> an cycles 110, 101, 011, 110, each held 4 cycles; dp_in=010 -> dp=0 only while an=101.
